// File: rtl/cam_stream_tx.sv
// Camera-style parallel video transmitter: 2-clk byte slots, vsync/href framing,
// pixels taken from an external pixel bus or an internal line/column test pattern.
//
// state  | meaning
// IDLE   | stopped, all outputs low, waiting for enable
// VSYNC  | sync lines, cam_vsync high
// VBP    | vertical back porch lines
// ACTIVE | picture lines: href slots then H_BLANK blank slots
// VFP    | vertical front porch; frame_done on its last clk
module cam_stream_tx #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10,
  parameter int ADDR_W      = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              pattern_sel,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_rd,
  input  logic [15:0]       pix_data,
  output logic              cam_pclk,
  output logic              cam_vsync,
  output logic              cam_href,
  output logic [7:0]        cam_data,
  output logic              frame_done,
  output logic              busy
);

  localparam int LINE_SLOTS = 2*H_ACTIVE + H_BLANK;
  localparam int HREF_SLOTS = 2*H_ACTIVE;
  localparam int SLOT_W     = $clog2(LINE_SLOTS);
  localparam int LINE_W     = 16;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(LINE_SLOTS - 1);
  localparam logic [SLOT_W-1:0] HREF_END  = SLOT_W'(HREF_SLOTS);
  localparam logic [LINE_W-1:0] VS_LAST   = LINE_W'(VSYNC_LINES - 1);
  localparam logic [LINE_W-1:0] VBP_LAST  = LINE_W'(VBP_LINES - 1);
  localparam logic [LINE_W-1:0] ACT_LAST  = LINE_W'(V_ACTIVE - 1);
  localparam logic [LINE_W-1:0] VFP_LAST  = LINE_W'(VFP_LINES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(H_ACTIVE*V_ACTIVE - 1);

  typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

  state_t              state, nxt_state;
  logic                ph;
  logic [SLOT_W-1:0]   slot, nxt_slot;
  logic [LINE_W-1:0]   vline, nxt_vline, lim;
  logic [ADDR_W-1:0]   addr;
  logic                pat_q;
  logic [15:0]         pix_q;
  logic                slot_end, line_last, frame_end, start, href, cap;
  logic [7:0]          px;
  logic [15:0]         src_pix, pixel;

  always_comb begin
    lim = '0;
    case (state)
      VSYNC:   lim = VS_LAST;
      VBP:     lim = VBP_LAST;
      ACTIVE:  lim = ACT_LAST;
      VFP:     lim = VFP_LAST;
      default: lim = '0;
    endcase
  end

  assign slot_end  = ph && (slot == SLOT_LAST);
  assign line_last = (vline == lim);
  assign frame_end = slot_end && line_last && (state == VFP);
  assign start     = ((state == IDLE) || frame_end) && enable;

  always_comb begin
    nxt_state = state;
    nxt_slot  = slot;
    nxt_vline = vline;
    if (state == IDLE) begin
      if (enable) nxt_state = VSYNC;
    end else if (ph) begin
      if (slot_end) begin
        nxt_slot = '0;
        if (line_last) begin
          nxt_vline = '0;
          case (state)
            VSYNC:   nxt_state = VBP;
            VBP:     nxt_state = ACTIVE;
            ACTIVE:  nxt_state = VFP;
            VFP:     nxt_state = enable ? VSYNC : IDLE;
            default: nxt_state = IDLE;
          endcase
        end else begin
          nxt_vline = vline + 1'b1;
        end
      end else begin
        nxt_slot = slot + 1'b1;
      end
    end
  end

  // Read is issued in the ph=1 cycle whose successor slot is an even href slot.
  assign pix_rd = ph && !pat_q && (nxt_state == ACTIVE) &&
                  (nxt_slot < HREF_END) && !nxt_slot[0];

  assign href = (state == ACTIVE) && (slot < HREF_END);
  assign cap  = href && !slot[0] && !ph && !pat_q;
  assign px   = 8'(slot >> 1);

  // Pixel bus data is only valid in the first cycle of the high-byte slot,
  // so that cycle uses it directly and the rest of the pixel uses the capture.
  assign src_pix = (!ph && !slot[0]) ? pix_data : pix_q;
  assign pixel   = pat_q ? {vline[7:0], px} : src_pix;

  assign cam_data   = href ? (slot[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
  assign cam_href   = href;
  assign cam_vsync  = (state == VSYNC);
  assign cam_pclk   = ph;
  assign frame_done = frame_end;
  assign busy       = (state != IDLE);
  assign pix_addr   = addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ph    <= 1'b0;
      slot  <= '0;
      vline <= '0;
      addr  <= '0;
      pat_q <= 1'b0;
      pix_q <= '0;
    end else begin
      state <= nxt_state;
      ph    <= (state != IDLE) && !ph;
      slot  <= nxt_slot;
      vline <= nxt_vline;
      if (start) begin
        addr  <= '0;
        pat_q <= pattern_sel;
      end else if (pix_rd) begin
        addr <= (addr == ADDR_LAST) ? '0 : addr + 1'b1;
      end
      if (cap) pix_q <= pix_data;
    end
  end

endmodule

// File: tb/tb_cam_stream_tx.sv
// Directed bench for cam_stream_tx with a tiny 4x3 frame: framing, bytes,
// pixel reads, enable drop, mid-line reset and back-to-back frames.
module tb_cam_stream_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        pattern_sel = 1'b0;
  logic [18:0] pix_addr;
  logic        pix_rd;
  logic [15:0] pix_data = 16'hDEAD;
  logic        cam_pclk, cam_vsync, cam_href, frame_done, busy;
  logic [7:0]  cam_data;

  int checks = 0;
  int failures = 0;

  cam_stream_tx #(
    .H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(2),
    .VSYNC_LINES(1), .VBP_LINES(1), .VFP_LINES(1), .ADDR_W(19)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
    .pix_addr(pix_addr), .pix_rd(pix_rd), .pix_data(pix_data),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pixel source: data valid exactly one clk after the read strobe.
  always @(posedge clk) pix_data <= pix_rd ? 16'hA000 + 16'(pix_addr) : 16'hDEAD;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {31'd0, busy, cam_vsync, cam_href, cam_pclk, pix_rd, frame_done, cam_data, pix_addr};
  endfunction

  // Runs one frame from the next clk edge and checks it; called right after a negedge.
  task automatic frame(input string tag, input bit pat, input bit drop_en);
    int cyc = 0, vs = 0, first_vs = 0, nbytes = 0, nrd = 0;
    int rd_bad = 0, byte_bad = 0, addr_bad = 0;
    bit done = 0;
    logic [7:0] eb;
    pattern_sel = pat;
    enable = 1'b1;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cam_vsync) begin
        vs++;
        if (first_vs == 0) first_vs = cyc;
      end
      if (pix_rd) begin
        if (!cam_pclk) rd_bad++;
        if (pix_addr != 19'(nrd)) addr_bad++;
        nrd++;
      end
      if (cam_href && cam_pclk) begin
        if (nbytes % 2 == 0) eb = pat ? 8'(nbytes / 8) : 8'hA0;
        else eb = pat ? 8'((nbytes % 8) / 2) : 8'((nbytes / 8) * 4 + (nbytes % 8) / 2);
        if (cam_data !== eb) byte_bad++;
        nbytes++;
      end
      if (!cam_href && cam_data !== 8'h00) byte_bad++;
      if (nbytes == 12) pattern_sel = ~pat;
      if (drop_en && nbytes == 10) enable = 1'b0;
      if (frame_done) done = 1;
    end
    chk({tag, " done_cyc"}, 64'(cyc), 64'd120);
    chk({tag, " vsync_cyc"}, 64'(vs), 64'd20);
    chk({tag, " vsync_first"}, 64'(first_vs), 64'd1);
    chk({tag, " bytes"}, 64'(nbytes), 64'd24);
    chk({tag, " byte_bad"}, 64'(byte_bad), 64'd0);
    chk({tag, " reads"}, 64'(nrd), pat ? 64'd0 : 64'd12);
    chk({tag, " rd_phase"}, 64'(rd_bad), 64'd0);
    chk({tag, " addr_bad"}, 64'(addr_bad), 64'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_outs", outs(), 64'd0);

    frame("pat", 1'b1, 1'b0);
    frame("src", 1'b0, 1'b0);
    frame("src_drop", 1'b0, 1'b1);
    @(negedge clk);
    chk("drop_idle", outs(), 64'd0);
    repeat (4) @(negedge clk);
    chk("stay_idle", outs(), 64'd0);

    enable = 1'b1;
    pattern_sel = 1'b1;
    n = 0;
    while (!cam_href && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("href_seen", 64'(cam_href), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midline_reset", outs(), 64'd0);
    reset = 1'b0;
    frame("after_rst", 1'b0, 1'b1);
    @(negedge clk);
    chk("final_idle", outs(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
